// File: rtl/arcade_video_timing.sv
// Raster timing generator: pixel/half-pixel clock enables, H/V counters,
// flip-aware vertical count, registered blanking, sync and line/frame strobes.
// Every decode is taken from the next counter values. As a result, counters,
// decodes and strobes all change on the same clock edge.
module arcade_video_timing #(
   parameter int CLK_DIV        = 4,
   parameter int H_W            = 10,
   parameter int V_W            = 9,
   parameter int H_TOTAL        = 384,
   parameter int H_ACTIVE       = 256,
   parameter int H_SYNC_START   = 288,
   parameter int H_SYNC_END     = 320,
   parameter int V_TOTAL        = 264,
   parameter int V_ACTIVE_START = 16,
   parameter int V_ACTIVE_END   = 240,
   parameter int V_SYNC_START   = 248,
   parameter int V_SYNC_END     = 251
) (
   input  logic           I_CLK,
   input  logic           I_RESETn,
   input  logic           I_VFLIP,
   output logic           O_CEN_PIX,
   output logic           O_CEN_HALF,
   output logic [H_W-1:0] O_H_CNT,
   output logic [V_W-1:0] O_V_CNT,
   output logic [V_W-1:0] O_VF_CNT,
   output logic           O_HBLANKn,
   output logic           O_VBLANKn,
   output logic           O_CBLANKn,
   output logic           O_HSYNCn,
   output logic           O_VSYNCn,
   output logic           O_LINE_STB,
   output logic           O_FRAME_STB
);

   // Parameter sanity: a bad combination stops elaboration.
   if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_div
      $error("arcade_video_timing: CLK_DIV must be even and >= 2");
   end
   if (H_ACTIVE >= H_TOTAL || H_SYNC_END > H_TOTAL) begin : g_bad_h_end
      $error("arcade_video_timing: horizontal window exceeds H_TOTAL");
   end
   if (V_ACTIVE_END > V_TOTAL || V_SYNC_END > V_TOTAL) begin : g_bad_v_end
      $error("arcade_video_timing: vertical window exceeds V_TOTAL");
   end
   if (H_SYNC_START > H_SYNC_END || V_ACTIVE_START > V_ACTIVE_END ||
       V_SYNC_START > V_SYNC_END) begin : g_bad_order
      $error("arcade_video_timing: a window start is greater than its end");
   end
   if (longint'(H_TOTAL) > (longint'(1) << H_W) ||
       longint'(V_TOTAL) > (longint'(1) << V_W)) begin : g_bad_width
      $error("arcade_video_timing: counter width too small for total");
   end

   localparam int P_W = $clog2(CLK_DIV);
   localparam logic [P_W-1:0] P_LAST = P_W'(CLK_DIV - 1);
   localparam logic [P_W-1:0] P_HALF = P_W'(CLK_DIV / 2);
   localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
   localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);
   // Mirror axis of the active window; modular subtraction gives the truncation.
   localparam logic [V_W-1:0] VF_SUM = V_W'(V_ACTIVE_START + V_ACTIVE_END - 1);

   logic [P_W-1:0] p_reg, p_next;
   logic [H_W-1:0] h_reg, h_next;
   logic [V_W-1:0] v_reg, v_next;
   logic [V_W-1:0] vf_reg, vf_next;
   logic           flip_reg, flip_next;
   logic           pix_tick, h_wrap;
   logic           cen_pix_reg, cen_pix_next, cen_half_reg, cen_half_next;
   logic           hblank_n_reg, hblank_n_next, vblank_n_reg, vblank_n_next;
   logic           cblank_n_reg, cblank_n_next;
   logic           hsync_n_reg, hsync_n_next, vsync_n_reg, vsync_n_next;
   logic           line_stb_reg, line_stb_next, frame_stb_reg, frame_stb_next;

   // Next-state for prescaler, counters, flip latch and all decoded outputs.
   always_comb begin
      pix_tick  = (p_reg == P_LAST);
      h_wrap    = pix_tick && (h_reg == H_LAST);
      p_next    = pix_tick ? '0 : p_reg + 1'b1;
      h_next    = h_reg;
      v_next    = v_reg;
      flip_next = flip_reg;
      if (pix_tick) begin
         h_next = (h_reg == H_LAST) ? '0 : h_reg + 1'b1;
      end
      if (h_wrap) begin
         v_next    = (v_reg == V_LAST) ? '0 : v_reg + 1'b1;
         flip_next = I_VFLIP;   // only sampled at a line boundary, so a line never tears
      end
      cen_pix_next   = pix_tick;
      cen_half_next  = (p_next == '0) || (p_next == P_HALF);
      hblank_n_next  = int'(h_next) < H_ACTIVE;
      vblank_n_next  = (int'(v_next) >= V_ACTIVE_START) && (int'(v_next) < V_ACTIVE_END);
      cblank_n_next  = hblank_n_next && vblank_n_next;
      hsync_n_next   = !((int'(h_next) >= H_SYNC_START) && (int'(h_next) < H_SYNC_END));
      vsync_n_next   = !((int'(v_next) >= V_SYNC_START) && (int'(v_next) < V_SYNC_END));
      line_stb_next  = h_wrap;
      frame_stb_next = h_wrap && (int'(v_next) == V_ACTIVE_END);
      vf_next        = (vblank_n_next && flip_next) ? (VF_SUM - v_next) : v_next;
   end

   // State and output registers, cleared asynchronously.
   always_ff @(posedge I_CLK or negedge I_RESETn) begin
      if (!I_RESETn) begin
         p_reg         <= '0;
         h_reg         <= '0;
         v_reg         <= '0;
         vf_reg        <= '0;
         flip_reg      <= 1'b0;
         cen_pix_reg   <= 1'b0;
         cen_half_reg  <= 1'b0;
         hblank_n_reg  <= 1'b1;
         vblank_n_reg  <= 1'b0;
         cblank_n_reg  <= 1'b0;
         hsync_n_reg   <= 1'b1;
         vsync_n_reg   <= 1'b1;
         line_stb_reg  <= 1'b0;
         frame_stb_reg <= 1'b0;
      end else begin
         p_reg         <= p_next;
         h_reg         <= h_next;
         v_reg         <= v_next;
         vf_reg        <= vf_next;
         flip_reg      <= flip_next;
         cen_pix_reg   <= cen_pix_next;
         cen_half_reg  <= cen_half_next;
         hblank_n_reg  <= hblank_n_next;
         vblank_n_reg  <= vblank_n_next;
         cblank_n_reg  <= cblank_n_next;
         hsync_n_reg   <= hsync_n_next;
         vsync_n_reg   <= vsync_n_next;
         line_stb_reg  <= line_stb_next;
         frame_stb_reg <= frame_stb_next;
      end
   end

   assign O_CEN_PIX   = cen_pix_reg;
   assign O_CEN_HALF  = cen_half_reg;
   assign O_H_CNT     = h_reg;
   assign O_V_CNT     = v_reg;
   assign O_VF_CNT    = vf_reg;
   assign O_HBLANKn   = hblank_n_reg;
   assign O_VBLANKn   = vblank_n_reg;
   assign O_CBLANKn   = cblank_n_reg;
   assign O_HSYNCn    = hsync_n_reg;
   assign O_VSYNCn    = vsync_n_reg;
   assign O_LINE_STB  = line_stb_reg;
   assign O_FRAME_STB = frame_stb_reg;

endmodule

// File: tb/tb_arcade_video_timing.sv
// Bench for arcade_video_timing: a default instance and a small non-default
// instance. Both are compared every cycle against a closed-form model. The
// model derives every output from the number of clocks since reset release.
// A table of hand-derived vectors and a few hand sequences cover the
// multi-cycle corners.
module tb_arcade_video_timing;

   localparam int A_D = 4, A_HT = 384, A_HA = 256, A_HSS = 288, A_HSE = 320;
   localparam int A_VT = 264, A_VAS = 16, A_VAE = 240, A_VSS = 248, A_VSE = 251, A_VW = 9;
   localparam int B_D = 2, B_HW = 9, B_HT = 320, B_HA = 256, B_HSS = 280, B_HSE = 300;
   localparam int B_VT = 11, B_VAS = 2, B_VAE = 8, B_VSS = 9, B_VSE = 10, B_VW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a_n, rst_b_n, vflip_a, vflip_b;
   logic a_cen_pix, a_cen_half, a_hb, a_vb, a_cb, a_hs, a_vs, a_ls, a_fs;
   logic [9:0] a_h;
   logic [8:0] a_v, a_vf;
   logic b_cen_pix, b_cen_half, b_hb, b_vb, b_cb, b_hs, b_vs, b_ls, b_fs;
   logic [B_HW-1:0] b_h;
   logic [B_VW-1:0] b_v, b_vf;

   arcade_video_timing dut_a (
      .I_CLK(clk), .I_RESETn(rst_a_n), .I_VFLIP(vflip_a),
      .O_CEN_PIX(a_cen_pix), .O_CEN_HALF(a_cen_half),
      .O_H_CNT(a_h), .O_V_CNT(a_v), .O_VF_CNT(a_vf),
      .O_HBLANKn(a_hb), .O_VBLANKn(a_vb), .O_CBLANKn(a_cb),
      .O_HSYNCn(a_hs), .O_VSYNCn(a_vs),
      .O_LINE_STB(a_ls), .O_FRAME_STB(a_fs)
   );

   arcade_video_timing #(
      .CLK_DIV(B_D), .H_W(B_HW), .V_W(B_VW),
      .H_TOTAL(B_HT), .H_ACTIVE(B_HA), .H_SYNC_START(B_HSS), .H_SYNC_END(B_HSE),
      .V_TOTAL(B_VT), .V_ACTIVE_START(B_VAS), .V_ACTIVE_END(B_VAE),
      .V_SYNC_START(B_VSS), .V_SYNC_END(B_VSE)
   ) dut_b (
      .I_CLK(clk), .I_RESETn(rst_b_n), .I_VFLIP(vflip_b),
      .O_CEN_PIX(b_cen_pix), .O_CEN_HALF(b_cen_half),
      .O_H_CNT(b_h), .O_V_CNT(b_v), .O_VF_CNT(b_vf),
      .O_HBLANKn(b_hb), .O_VBLANKn(b_vb), .O_CBLANKn(b_cb),
      .O_HSYNCn(b_hs), .O_VSYNCn(b_vs),
      .O_LINE_STB(b_ls), .O_FRAME_STB(b_fs)
   );

   typedef struct packed {
      logic        cen_pix, cen_half;
      logic [31:0] h, v, vf;
      logic        hb, vb, cb, hs, vs, line_s, frame_s;
   } obs_t;

   typedef struct {
      longint n;
      int     h, v;
      bit     cp, ch, hb, hs, ls;
   } vec_t;

   localparam int NT = 15;
   vec_t   tbl[NT];
   int     tidx;
   int     checks, errors;
   longint n_a, n_b;
   bit     flip_a, flip_b;
   obs_t   rst_exp;

   // Closed-form reference: outputs after n clocks since release.
   function automatic obs_t ref_model(input longint n, input bit flip, input int D,
         input int HT, input int HA, input int HSS, input int HSE, input int VT,
         input int VAS, input int VAE, input int VSS, input int VSE, input int VW);
      obs_t   o;
      longint pix = n / D;
      longint ph  = n % D;
      int     h   = int'(pix % HT);
      int     v   = int'((pix / HT) % VT);
      o.cen_pix  = (n > 0) && (ph == 0);
      o.cen_half = (n > 0) && (ph == 0 || ph == D / 2);
      o.h        = h;
      o.v        = v;
      o.hb       = h < HA;
      o.vb       = (v >= VAS) && (v < VAE);
      o.cb       = o.hb && o.vb;
      o.hs       = !(h >= HSS && h < HSE);
      o.vs       = !(v >= VSS && v < VSE);
      o.line_s   = o.cen_pix && (h == 0);
      o.frame_s  = o.line_s && (v == VAE);
      o.vf       = (o.vb && flip) ? ((VAS + VAE - 1 - v) & ((1 << VW) - 1)) : v;
      return o;
   endfunction

   function automatic bit is_line(input longint n, input int D, input int HT);
      return (n > 0) && (n % D == 0) && ((n / D) % HT == 0);
   endfunction

   function automatic obs_t obs_a();
      obs_t o;
      o.cen_pix = a_cen_pix; o.cen_half = a_cen_half;
      o.h = 32'(a_h); o.v = 32'(a_v); o.vf = 32'(a_vf);
      o.hb = a_hb; o.vb = a_vb; o.cb = a_cb; o.hs = a_hs; o.vs = a_vs;
      o.line_s = a_ls; o.frame_s = a_fs;
      return o;
   endfunction

   function automatic obs_t obs_b();
      obs_t o;
      o.cen_pix = b_cen_pix; o.cen_half = b_cen_half;
      o.h = 32'(b_h); o.v = 32'(b_v); o.vf = 32'(b_vf);
      o.hb = b_hb; o.vb = b_vb; o.cb = b_cb; o.hs = b_hs; o.vs = b_vs;
      o.line_s = b_ls; o.frame_s = b_fs;
      return o;
   endfunction

   function automatic logic [8:0] flags(input obs_t o);
      return {o.cen_pix, o.cen_half, o.hb, o.vb, o.cb, o.hs, o.vs, o.line_s, o.frame_s};
   endfunction

   task automatic check(input string name, input longint n, input obs_t got, input obs_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s n=%0d got h=%0d v=%0d vf=%0d flags=%b, expected h=%0d v=%0d vf=%0d flags=%b",
                  name, n, got.h, got.v, got.vf, flags(got), exp.h, exp.v, exp.vf, flags(exp));
      end
   endtask

   task automatic check_val(input string name, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, got, exp);
      end else begin
         $display("check %s = %0d ok", name, got);
      end
   endtask

   // One clock: advance both models, then compare both instances on the falling edge.
   task automatic cycle();
      obs_t o;
      bit   ok;
      @(posedge clk);
      if (rst_a_n) begin
         n_a++;
         if (is_line(n_a, A_D, A_HT)) flip_a = vflip_a;
      end
      if (rst_b_n) begin
         n_b++;
         if (is_line(n_b, B_D, B_HT)) flip_b = vflip_b;
      end
      @(negedge clk);
      check("run_a", n_a, obs_a(),
            ref_model(n_a, flip_a, A_D, A_HT, A_HA, A_HSS, A_HSE, A_VT, A_VAS, A_VAE, A_VSS, A_VSE, A_VW));
      check("run_b", n_b, obs_b(),
            ref_model(n_b, flip_b, B_D, B_HT, B_HA, B_HSS, B_HSE, B_VT, B_VAS, B_VAE, B_VSS, B_VSE, B_VW));
      if (tidx < NT && rst_a_n && n_a == tbl[tidx].n) begin
         o  = obs_a();
         ok = (o.h == 32'(tbl[tidx].h)) && (o.v == 32'(tbl[tidx].v)) && (o.cen_pix == tbl[tidx].cp) &&
              (o.cen_half == tbl[tidx].ch) && (o.hb == tbl[tidx].hb) && (o.hs == tbl[tidx].hs) &&
              (o.line_s == tbl[tidx].ls);
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL vec%0d n=%0d got h=%0d v=%0d cp=%b ch=%b hb=%b hs=%b ls=%b, expected h=%0d v=%0d cp=%b ch=%b hb=%b hs=%b ls=%b",
                     tidx, n_a, o.h, o.v, o.cen_pix, o.cen_half, o.hb, o.hs, o.line_s,
                     tbl[tidx].h, tbl[tidx].v, tbl[tidx].cp, tbl[tidx].ch, tbl[tidx].hb,
                     tbl[tidx].hs, tbl[tidx].ls);
         end else begin
            $display("vec%0d n=%0d h=%0d v=%0d ok", tidx, n_a, o.h, o.v);
         end
         tidx++;
      end
   endtask

   initial begin
      int     cnt, frames, hold_bad;
      checks = 0; errors = 0; tidx = 0;
      n_a = 0; n_b = 0; flip_a = 0; flip_b = 0;
      rst_exp = '{cen_pix: 1'b0, cen_half: 1'b0, h: 32'd0, v: 32'd0, vf: 32'd0,
                  hb: 1'b1, vb: 1'b0, cb: 1'b0, hs: 1'b1, vs: 1'b1, line_s: 1'b0, frame_s: 1'b0};
      //            n      h    v   cp ch hb hs ls   (default instance, clocks after release)
      tbl[0]  = '{1,       0,   0,  0, 0, 1, 1, 0};
      tbl[1]  = '{2,       0,   0,  0, 1, 1, 1, 0};
      tbl[2]  = '{3,       0,   0,  0, 0, 1, 1, 0};
      tbl[3]  = '{4,       1,   0,  1, 1, 1, 1, 0};
      tbl[4]  = '{5,       1,   0,  0, 0, 1, 1, 0};
      tbl[5]  = '{1020,    255, 0,  1, 1, 1, 1, 0};
      tbl[6]  = '{1024,    256, 0,  1, 1, 0, 1, 0};
      tbl[7]  = '{1152,    288, 0,  1, 1, 0, 0, 0};
      tbl[8]  = '{1276,    319, 0,  1, 1, 0, 0, 0};
      tbl[9]  = '{1280,    320, 0,  1, 1, 0, 1, 0};
      tbl[10] = '{1532,    383, 0,  1, 1, 0, 1, 0};
      tbl[11] = '{1536,    0,   1,  1, 1, 1, 1, 1};
      tbl[12] = '{1537,    0,   1,  0, 0, 1, 1, 0};
      tbl[13] = '{1540,    1,   1,  1, 1, 1, 1, 0};
      tbl[14] = '{24576,   0,   16, 1, 1, 1, 1, 1};

      // Reset held with a flip request present: the latch must stay clear.
      rst_a_n = 1'b0; rst_b_n = 1'b0; vflip_a = 1'b1; vflip_b = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_a", 0, obs_a(), rst_exp);
      check("reset_b", 0, obs_b(), rst_exp);
      vflip_a = 1'b0; vflip_b = 1'b0;
      rst_a_n = 1'b1; rst_b_n = 1'b1;

      // Random phase: 18 default lines, with random flip toggles and random
      // asynchronous resets of the small instance.
      for (int i = 0; i < 18 * A_HT * A_D + 8; i++) begin
         cycle();
         if ($urandom_range(0, 63) == 0) vflip_a = ~vflip_a;
         if ($urandom_range(0, 63) == 0) vflip_b = ~vflip_b;
         if (!rst_b_n) begin
            rst_b_n = 1'b1;
         end else if ($urandom_range(0, 2999) == 0) begin
            rst_b_n = 1'b0; n_b = 0; flip_b = 0;
            #1 check("async_reset_b", n_b, obs_b(), rst_exp);
         end
      end

      // Mid-line reset of the small instance: it must clear within the same cycle.
      vflip_b = 1'b0;
      rst_b_n = 1'b0; n_b = 0; flip_b = 0;
      #1 check("midline_reset_b", 0, obs_b(), rst_exp);
      cycle();
      rst_b_n = 1'b1;

      // Flip raised at H=100 on line 3: line 3 keeps VF=3, line 4 shows 9-4=5.
      for (int k = 0; k < 5000 && n_b < (3 * B_HT + 100) * B_D; k++) cycle();
      check_val("b_h_at_flip", b_h, 100);
      vflip_b = 1'b1;
      hold_bad = 0;
      for (int k = 0; k < 5000 && n_b < 4 * B_HT * B_D - 1; k++) begin
         cycle();
         if (b_vf != 4'd3) hold_bad++;
      end
      check_val("flip_hold_line3", hold_bad, 0);
      cycle();
      check_val("flip_line4_vf", b_vf, 5);

      // Several toggles in line 4, ending low: line 5 is unflipped.
      for (int k = 0; k < 5000 && n_b < 5 * B_HT * B_D; k++) begin
         cycle();
         if (n_b % 97 == 0) vflip_b = ~vflip_b;
         if (n_b >= 5 * B_HT * B_D - 4) vflip_b = 1'b0;
      end
      check_val("flip_line5_vf", b_vf, 5);

      // Flip held high: line 6 flipped (9-6=3), line 9 outside window shows V.
      vflip_b = 1'b1;
      for (int k = 0; k < 5000 && n_b < 6 * B_HT * B_D; k++) cycle();
      check_val("flip_line6_vf", b_vf, 3);
      for (int k = 0; k < 5000 && n_b < 9 * B_HT * B_D; k++) cycle();
      check_val("outside_window_vf", b_vf, 9);

      // Line period of the small instance, from strobe to strobe.
      cnt = 0;
      for (int k = 0; k < 2000; k++) begin
         cycle();
         cnt++;
         if (b_ls) break;
      end
      check_val("b_line_period", cnt, B_HT * B_D);

      // One full frame: exactly one frame strobe, seen at V=VAE, H=0.
      frames = 0;
      for (int k = 0; k < B_HT * B_VT * B_D; k++) begin
         cycle();
         if (b_fs) begin
            frames++;
            check_val("b_frame_v", b_v, B_VAE);
            check_val("b_frame_h", b_h, 0);
         end
      end
      check_val("b_frames_per_frame", frames, 1);
      check_val("table_vectors_seen", tidx, NT);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/arcade_video_timing.md
# arcade_video_timing

Parametrised raster timing generator for the arcade cores.
- Derives pixel-rate and double-rate clock enables from the single master clock.
- Produces horizontal and vertical counters, a flip-aware vertical count, registered blanking and sync, and line and frame strobes.
- Generalises the fixed 384×264, 24 MHz / 6 MHz timing used today. Totals, active windows, sync positions, divide ratio and counter widths are all parameters.
- Sits at the top of each core and feeds the video, sprite-DMA and CPU-interrupt logic.

## Interface
Parameters:
- CLK_DIV, 4: master clocks per pixel; must be even and ≥2.
- H_W, 10: width of the H counter.
- V_W, 9: width of the V counter and the VF counter.
- H_TOTAL, 384: pixels per line.
- H_ACTIVE, 256: visible pixels are H in [0, H_ACTIVE).
- H_SYNC_START, 288; H_SYNC_END, 320: HSYNC is active for H in [start, end).
- V_TOTAL, 264: lines per frame.
- V_ACTIVE_START, 16; V_ACTIVE_END, 240: visible lines are V in [start, end).
- V_SYNC_START, 248; V_SYNC_END, 251: VSYNC is active for V in [start, end).

Ports:
- I_CLK  in  1  master clock.
- I_RESETn  in  1  reset, asynchronous, active-low.
- I_VFLIP  in  1  vertical flip request.
- O_CEN_PIX  out  1  one-cycle pixel enable.
- O_CEN_HALF  out  1  enable at twice the pixel rate.
- O_H_CNT  out  H_W  horizontal count.
- O_V_CNT  out  V_W  vertical count.
- O_VF_CNT  out  V_W  flip-adjusted vertical count.
- O_HBLANKn, O_VBLANKn, O_CBLANKn  out  1 each  blanking, active low. CBLANKn = HBLANKn & VBLANKn.
- O_HSYNCn, O_VSYNCn  out  1 each  sync, active low.
- O_LINE_STB  out  1  start-of-line pulse.
- O_FRAME_STB  out  1  start-of-vblank pulse, used as the interrupt source.

## Operation
Prescaler:
- Prescaler p counts 0..CLK_DIV-1 on every I_CLK edge and wraps to 0.
- A pixel tick is the edge on which p == CLK_DIV-1.

Counters:
- On each pixel tick, H advances by 1. H wraps from H_TOTAL-1 to 0.
- On the H wrap, V also advances. V wraps from V_TOTAL-1 to 0.

Decoded outputs:
- All outputs are registered.
- Decodes are computed from the next counter values, so counters, blanks, syncs and strobes change on the same edge with zero skew.
- HBLANKn = (H < H_ACTIVE).
- VBLANKn = (V_ACTIVE_START ≤ V < V_ACTIVE_END).
- HSYNCn and VSYNCn are low inside their sync windows.

Enables:
- O_CEN_PIX is high for exactly the one I_CLK cycle following each pixel tick.
- O_CEN_HALF is high in the cycles where p == 0 and where p == CLK_DIV/2. It therefore coincides with every O_CEN_PIX.

Strobes:
- O_LINE_STB is high in the O_CEN_PIX cycle in which H becomes 0.
- O_FRAME_STB is high in the O_CEN_PIX cycle in which H becomes 0 and V becomes V_ACTIVE_END.

Flip:
- I_VFLIP is sampled into flip_q only on the pixel tick where H wraps to 0. A flip change therefore never tears a line.
- Inside the active V window: O_VF_CNT = flip_q ? (V_ACTIVE_START+V_ACTIVE_END-1-V) : V, truncated to V_W bits.
- Outside the active window: O_VF_CNT = V.
- With the defaults, the flipped value is 255-V.

Elaboration checks (out-of-range parameters must fail elaboration):
- CLK_DIV is odd or less than 2.
- H_ACTIVE ≥ H_TOTAL.
- Any window end exceeds its total.
- Any start is greater than its end.
- H_TOTAL > 2^H_W or V_TOTAL > 2^V_W.

## Timing
Reset (asynchronous, active while I_RESETn is low):
- p = 0, H = 0, V = 0, flip_q = 0.
- O_CEN_PIX = 0, O_CEN_HALF = 0, O_LINE_STB = 0, O_FRAME_STB = 0.
- O_HSYNCn = 1, O_VSYNCn = 1.
- O_HBLANKn = 1, O_VBLANKn = 0, O_CBLANKn = 0.
- O_VF_CNT = 0.

After release:
- The first pixel tick is the CLK_DIV-th edge after release. On that edge H becomes 1 and O_CEN_PIX goes high.
- Line period is H_TOTAL×CLK_DIV clocks. Frame period is H_TOTAL×V_TOTAL×CLK_DIV clocks; the default is 405504.

Boundary conditions:
- Simultaneous H and V wrap: both counters go to 0 on the same edge, and O_LINE_STB pulses.
- Reset asserted mid-frame: all state returns to reset values immediately. No partial strobe is emitted.
- I_VFLIP toggling several times within one line: only the value present at the next H wrap is used.

## Test plan
- **Reset:** hold I_RESETn low, then release. Required: outputs equal the reset values listed above; O_CEN_PIX first rises 4 clocks after release, with H = 1.
- **Enable cadence (defaults):** run 40 clocks. Required: O_CEN_PIX exactly every 4 clocks; O_CEN_HALF exactly every 2 clocks, coinciding with each O_CEN_PIX.
- **Line wrap:** observe the H 383→0 transition. Required: V increments, O_LINE_STB is one clock wide, O_HSYNCn is low for H 288..319, O_HBLANKn is low for H 256..383.
- **Frame:** run 405504 clocks. Required: exactly one O_FRAME_STB, at V = 240 and H = 0; O_VSYNCn is low for lines 248..250; V wraps from 263 to 0.
- **Flip:** raise I_VFLIP at H = 100 on line 50. Required: O_VF_CNT stays 50 for the rest of that line; the next line shows 204 (= 255-51); outside the active window O_VF_CNT = V.
- **Non-default parameters:** CLK_DIV = 2, H_TOTAL = 320, H_ACTIVE = 256. Required: O_CEN_PIX every 2 clocks and line period of 640 clocks. Also assert reset mid-line and check all state clears within the same cycle.
